// File: rtl/irq_arb_seq.sv
// Nine-channel, three-class interrupt arbiter: edge-captured pending latches, enable mask,
// fixed-priority winner selection and a valid/ack/eoi handshake toward the CPU.
//
// state     | meaning
// S_IDLE    | nothing presented; arbitrate over eligible pending bits
// S_PRESENT | winner presented (irq_valid=1), waiting for irq_ack
// S_SERVICE | interrupt in service (busy=1), waiting for eoi
module irq_arb_seq #(
  parameter int NCH = 9,
  parameter int CHW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req_a,
  input  logic [NCH-1:0] req_b,
  input  logic [NCH-1:0] req_c,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wdata,
  output logic [NCH-1:0] mask,
  output logic [NCH-1:0] pending,
  output logic           irq_valid,
  output logic [CHW-1:0] irq_ch,
  output logic [1:0]     irq_cls,
  input  logic           irq_ack,
  input  logic           eoi,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t         r_state;
  logic [NCH-1:0] r_req_a_d, r_req_b_d, r_req_c_d;
  logic [NCH-1:0] r_pend_a, r_pend_b, r_pend_c;
  logic [NCH-1:0] r_mask;
  logic           r_valid;
  logic           r_busy;
  logic [CHW-1:0] r_ch;
  logic [1:0]     r_cls;

  logic [NCH-1:0] w_edge_a, w_edge_b, w_edge_c;
  logic [NCH-1:0] w_elig_a, w_elig_b, w_elig_c;
  logic [NCH-1:0] w_clr_sel, w_clr_a, w_clr_b, w_clr_c;
  logic           w_any;
  logic           w_ack_hit;
  logic [CHW-1:0] w_win_ch;
  logic [1:0]     w_win_cls;

  function automatic logic [CHW-1:0] f_lowest(input logic [NCH-1:0] v);
    logic [CHW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = CHW'(i);
    end
    return idx;
  endfunction

  assign w_edge_a = req_a & ~r_req_a_d;
  assign w_edge_b = req_b & ~r_req_b_d;
  assign w_edge_c = req_c & ~r_req_c_d;

  assign w_elig_a = r_pend_a & r_mask;
  assign w_elig_b = r_pend_b & r_mask;
  assign w_elig_c = r_pend_c & r_mask;
  assign w_any    = (|w_elig_a) | (|w_elig_b) | (|w_elig_c);

  always_comb begin
    w_win_ch  = '0;
    w_win_cls = 2'd0;
    if (|w_elig_a) begin
      w_win_ch  = f_lowest(w_elig_a);
      w_win_cls = 2'd0;
    end else if (|w_elig_b) begin
      w_win_ch  = f_lowest(w_elig_b);
      w_win_cls = 2'd1;
    end else if (|w_elig_c) begin
      w_win_ch  = f_lowest(w_elig_c);
      w_win_cls = 2'd2;
    end
  end

  // Ack clears only the presented winner's bit; a same-cycle edge re-sets it below.
  assign w_ack_hit = (r_state == S_PRESENT) && irq_ack;
  assign w_clr_sel = w_ack_hit ? (NCH'(1) << r_ch) : '0;
  assign w_clr_a   = (r_cls == 2'd0) ? w_clr_sel : '0;
  assign w_clr_b   = (r_cls == 2'd1) ? w_clr_sel : '0;
  assign w_clr_c   = (r_cls == 2'd2) ? w_clr_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_a_d <= '0;
      r_req_b_d <= '0;
      r_req_c_d <= '0;
      r_pend_a  <= '0;
      r_pend_b  <= '0;
      r_pend_c  <= '0;
      r_mask    <= '0;
    end else begin
      r_req_a_d <= req_a;
      r_req_b_d <= req_b;
      r_req_c_d <= req_c;
      r_pend_a  <= (r_pend_a & ~w_clr_a) | w_edge_a;
      r_pend_b  <= (r_pend_b & ~w_clr_b) | w_edge_b;
      r_pend_c  <= (r_pend_c & ~w_clr_c) | w_edge_c;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ch    <= '0;
      r_cls   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_valid <= 1'b1;
            r_ch    <= w_win_ch;
            r_cls   <= w_win_cls;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq_ack) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mask      = r_mask;
  assign pending   = r_pend_a | r_pend_b | r_pend_c;
  assign irq_valid = r_valid;
  assign irq_ch    = r_ch;
  assign irq_cls   = r_cls;
  assign busy      = r_busy;

endmodule

// File: doc/irq_arb_seq.md
Name: irq_arb_seq

Overview:
- Sequential 9-channel, 3-class interrupt arbiter/controller that sequences the combinational priority-resolution datapath used in our 27-channel interrupt benchmark.
- Captures request edges into pending latches, applies a per-channel enable mask, and resolves one winner.
- Presents the winner to the CPU over a valid/ack handshake and tracks in-service state until end-of-interrupt.
- Sits between peripheral request lines and the CPU interrupt input; used as a sequential train-set design for power-aware synthesis.

Parameters:
NCH, 9, number of channels (1..15).
CHW, 4, width of channel index output; must satisfy 2**CHW >= NCH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_a  input  NCH  class-A (highest class) request lines, synchronous to clk.
req_b  input  NCH  class-B request lines.
req_c  input  NCH  class-C (lowest class) request lines.
mask_we  input  1  write strobe for the enable mask.
mask_wdata  input  NCH  new mask value; bit=1 enables the channel.
mask  output  NCH  current enable mask.
pending  output  NCH  per-channel OR of the three class pending bits.
irq_valid  output  1  interrupt presented to CPU.
irq_ch  output  CHW  winning channel index.
irq_cls  output  2  winning class: 0=A, 1=B, 2=C.
irq_ack  input  1  CPU accepts the presented interrupt.
eoi  input  1  CPU end-of-interrupt.
busy  output  1  an interrupt is in service.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, all pending=0, edge-detect registers=0, mask=0 (all disabled), irq_valid=0, irq_ch=0, irq_cls=0, busy=0. Reset asserted mid-handshake aborts it; nothing is retained.
- Edge capture: pend_x[i] sets at a clk edge when req_x[i]=1 and the registered previous value of req_x[i] is 0. Levels held high do not re-set pending.
- Mask write: mask_we=1 loads mask_wdata at the edge. Mask gates eligibility only; pending bits of masked channels stay latched.
- Eligibility: eligible = pend & mask, per class.
- Winner selection:
  - Class A beats B, B beats C, regardless of channel.
  - Within a class, the lowest channel index wins.
- FSM states:
  - IDLE: if any eligible bit is set, latch winner into irq_ch/irq_cls and go to PRESENT; irq_valid=1 from the next cycle.
  - PRESENT: irq_valid=1; irq_ch/irq_cls held stable. There is no withdrawal or re-arbitration, even if mask clears or a higher-priority request arrives. On irq_ack=1: clear the winner's pending bit, go to SERVICE, irq_valid=0, busy=1 from the next cycle.
  - SERVICE: busy=1; irq_ch/irq_cls retain the last value. On eoi=1 go to IDLE with busy=0. No preemption (non-nested).
- Latency: request rising edge sampled at edge t sets pending after t; IDLE arbitrates at edge t+1; irq_valid=1 after edge t+1. Back-to-back: eoi at edge e gives IDLE after e, and the next irq_valid=1 after e+1.
- Simultaneous events:
  - A new edge on the same (ch,cls) in the same cycle as the ack clear: set wins, so the bit stays pending.
  - mask_we together with an IDLE arbitration: arbitration uses the pre-write mask.
  - irq_ack outside PRESENT is ignored. eoi outside SERVICE is ignored. irq_ack and eoi together in PRESENT: only ack is acted on.
- Outputs are registered; pending is a combinational OR of registered bits.

Test Plan:
1. Reset, then write mask=9'h1FF; pulse req_b[5] -> pending[5]=1 after one edge, irq_valid=1 after the second, irq_ch=5, irq_cls=1; ack -> pending[5]=0, busy=1; eoi -> busy=0, FSM idle.
2. In the same cycle assert req_c[0], req_b[3], req_a[7] -> winners are presented in order (7,A), (3,B), (0,C) across three ack/eoi cycles.
3. mask=0, pulse req_a[2] -> pending[2]=1, irq_valid stays 0 for 10 cycles; write mask bit 2 -> irq_valid=1 two edges later with irq_ch=2, irq_cls=0.
4. While in PRESENT with (4,C), pulse req_a[0] and clear mask -> irq_ch=4, irq_cls=2 held until ack; after eoi, (0,A) is not presented while masked.
5. Hold req_a[1] high across ack -> no re-trigger; then re-pulse req_a[1] coinciding with the ack of (1,A) -> pending[1] remains 1 and is re-presented after eoi.
6. Drop rst_n during PRESENT and during SERVICE -> all outputs 0 immediately (async), mask=0, and no spurious irq_valid after release.
